gig_eth_tx_frame_fifo: RTL

Store-and-forward transmit frame buffer that sits directly upstream of the gigabit MAC transmitter. It accepts byte-wide frames from the client/packet generator and commits each frame only after its last byte is written. It presents committed frames to the MAC using the dvld/ack byte-stream handshake. Because only complete frames are read, the MAC never sees a mid-frame underrun. Frames that overflow the buffer are dropped whole.

---
 rtl/gig_eth_tx_frame_fifo.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/gig_eth_tx_frame_fifo.sv
// Store-and-forward transmit frame buffer in front of the gigabit MAC. A frame becomes
// visible to the read side only once its EOF byte is written; oversized frames drop whole.
module gig_eth_tx_frame_fifo #(
    parameter int ADDR_WIDTH       = 12,
    parameter int MAX_FRAMES_WIDTH = 8
) (
    input  logic                        reset,
    input  logic                        tx_clk,
    input  logic [7:0]                  wr_data,
    input  logic                        wr_en,
    input  logic                        wr_eof,
    output logic                        wr_full,
    output logic                        wr_drop,
    output logic [MAX_FRAMES_WIDTH-1:0] frame_cnt,
    output logic [7:0]                  mac_tx_data,
    output logic                        mac_tx_dvld,
    output logic                        mac_tx_underrun,
    input  logic                        mac_tx_ack,
    output logic                        tx_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]           PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0]         ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MAX_FRAMES_WIDTH-1:0]   CNT_ONE  = {{(MAX_FRAMES_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MAX_FRAMES_WIDTH-1:0]   CNT_MAX  = {MAX_FRAMES_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_FRAME = 2'd1,
        WR_DROP  = 2'd2
    } wr_state_t;

    typedef enum logic [2:0] {
        RD_IDLE    = 3'd0,
        RD_FETCH   = 3'd1,
        RD_PRESENT = 3'd2,
        RD_STREAM  = 3'd3,
        RD_GAP     = 3'd4
    } rd_state_t;

    // Each entry is {eof, data}.
    logic [8:0] mem [DEPTH];

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] commit_ptr_q, commit_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;

    logic [MAX_FRAMES_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                        wr_full_q, wr_full_d;
    logic                        wr_drop_q, wr_drop_d;
    logic [7:0]                  mac_tx_data_q, mac_tx_data_d;
    logic                        mac_tx_dvld_q, mac_tx_dvld_d;
    logic                        tx_done_q, tx_done_d;

    logic                  wr_active;
    logic                  wr_overflow;
    logic                  mem_we;
    logic                  commit;
    logic                  drop;
    logic                  frame_done;
    logic                  byte0_accept;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] rd_addr_nxt;
    logic [8:0]            cur_word;
    logic [7:0]            nxt_data;

    // ---------------------------------------------------------------- write side
    // A byte overflows when the buffer is full, or when committing it would wrap the
    // frame counter; either way the whole frame is discarded.
    always_comb begin
        wr_active   = wr_en && (wr_state_q != WR_DROP);
        wr_overflow = wr_full_q || (wr_eof && (frame_cnt_q == CNT_MAX));
        mem_we      = wr_active && !wr_overflow;
        commit      = mem_we && wr_eof;
        drop        = wr_active && wr_overflow;
    end

    always_ff @(posedge tx_clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {wr_eof, wr_data};
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WR_IDLE, WR_FRAME: begin
                if (wr_en) begin
                    if (wr_overflow) begin
                        wr_state_d = wr_eof ? WR_IDLE : WR_DROP;
                    end else begin
                        wr_state_d = wr_eof ? WR_IDLE : WR_FRAME;
                    end
                end
            end
            WR_DROP: begin
                if (wr_en && wr_eof) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        wr_drop_d    = drop;
        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (commit) begin
            commit_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (drop) begin
            wr_ptr_d = commit_ptr_q;
        end
        // Compared against the pre-edge read pointer, so freed space shows up a cycle late.
        wr_full_d = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                    (wr_ptr_d[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    end

    // ---------------------------------------------------------------- read side
    // MAC handshake: mac_tx_dvld rises with byte 0 and holds it until mac_tx_ack is
    // sampled high while dvld is high; the rest of the frame then follows one byte per
    // cycle with no back-pressure, and dvld falls once the EOF byte has been shown.
    always_comb begin
        rd_addr      = rd_ptr_q[ADDR_WIDTH-1:0];
        rd_addr_nxt  = rd_addr + ADDR_ONE;
        cur_word     = mem[rd_addr];
        nxt_data     = mem[rd_addr_nxt][7:0];
        byte0_accept = mac_tx_dvld_q && mac_tx_ack;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (frame_cnt_q != '0) begin
                    rd_state_d = RD_FETCH;
                end
            end
            RD_FETCH: rd_state_d = RD_PRESENT;
            RD_PRESENT: begin
                if (byte0_accept) begin
                    rd_state_d = cur_word[8] ? RD_GAP : RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (cur_word[8]) begin
                    rd_state_d = RD_GAP;
                end
            end
            RD_GAP: rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // rd_ptr always addresses the byte currently held on mac_tx_data.
    always_comb begin
        mac_tx_data_d = mac_tx_data_q;
        mac_tx_dvld_d = 1'b0;
        tx_done_d     = 1'b0;
        rd_ptr_d      = rd_ptr_q;
        frame_done    = 1'b0;
        case (rd_state_q)
            RD_FETCH: begin
                mac_tx_data_d = cur_word[7:0];
            end
            RD_PRESENT: begin
                mac_tx_dvld_d = 1'b1;
                mac_tx_data_d = cur_word[7:0];
                if (byte0_accept) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    if (cur_word[8]) begin
                        mac_tx_dvld_d = 1'b0;
                        tx_done_d     = 1'b1;
                        frame_done    = 1'b1;
                    end else begin
                        mac_tx_data_d = nxt_data;
                    end
                end
            end
            RD_STREAM: begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                if (cur_word[8]) begin
                    tx_done_d  = 1'b1;
                    frame_done = 1'b1;
                end else begin
                    mac_tx_dvld_d = 1'b1;
                    mac_tx_data_d = nxt_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        case ({commit, frame_done})
            2'b10:   frame_cnt_d = frame_cnt_q + CNT_ONE;
            2'b01:   frame_cnt_d = frame_cnt_q - CNT_ONE;
            default: frame_cnt_d = frame_cnt_q;
        endcase
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            wr_state_q    <= WR_IDLE;
            rd_state_q    <= RD_IDLE;
            wr_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            rd_ptr_q      <= '0;
            frame_cnt_q   <= '0;
            wr_full_q     <= 1'b0;
            wr_drop_q     <= 1'b0;
            mac_tx_data_q <= '0;
            mac_tx_dvld_q <= 1'b0;
            tx_done_q     <= 1'b0;
        end else begin
            wr_state_q    <= wr_state_d;
            rd_state_q    <= rd_state_d;
            wr_ptr_q      <= wr_ptr_d;
            commit_ptr_q  <= commit_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            frame_cnt_q   <= frame_cnt_d;
            wr_full_q     <= wr_full_d;
            wr_drop_q     <= wr_drop_d;
            mac_tx_data_q <= mac_tx_data_d;
            mac_tx_dvld_q <= mac_tx_dvld_d;
            tx_done_q     <= tx_done_d;
        end
    end

    assign wr_full         = wr_full_q;
    assign wr_drop         = wr_drop_q;
    assign frame_cnt       = frame_cnt_q;
    assign mac_tx_data     = mac_tx_data_q;
    assign mac_tx_dvld     = mac_tx_dvld_q;
    assign mac_tx_underrun = 1'b0;
    assign tx_done         = tx_done_q;

endmodule
